// File: rtl/context_switch_timer_pkg.sv
// Shared types and constants for the preemption timer (package galetron_ctx_pkg).
package galetron_ctx_pkg;

  localparam int              PC_WIDTH      = 12;
  localparam int              QUANTUM_WIDTH = 16;
  localparam logic [15:0]     RESET_QUANTUM = 16'd1000;
  // OS handler entry the PC vectors to on an exchange; the PC block owns the jump.
  localparam logic [11:0]     HANDLER_ADDR  = 12'd1083;

  typedef enum logic [1:0] {
    IDLE,
    COUNTING,
    KERNEL
  } ctx_state_e;

endpackage

// File: rtl/quantum_down_counter.sv
// Loadable down-counter holding the remaining quantum; stops at zero.
module quantum_down_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)                    count_d = load_val_i;
    else if (dec_i && count_q != '0) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/context_switch_timer.sv
// Instruction-quantum preemption controller feeding the PC's context-exchange jump.
// Optional preemption statistics counter enabled by CTX_PREEMPT_STATS_EN.
module context_switch_timer #(
  parameter int                          PC_WIDTH      = galetron_ctx_pkg::PC_WIDTH,
  parameter int                          QUANTUM_WIDTH = galetron_ctx_pkg::QUANTUM_WIDTH,
  parameter logic [QUANTUM_WIDTH-1:0]    RESET_QUANTUM = galetron_ctx_pkg::RESET_QUANTUM
) (
  input  logic                     clock,
  input  logic                     resetCPU,
  input  logic [PC_WIDTH-1:0]      programCounter,
  input  logic                     HLT,
  input  logic                     ctrl_transfer,
  input  logic                     cfg_write,
  input  logic                     cfg_enable,
  input  logic [QUANTUM_WIDTH-1:0] cfg_quantum,
  input  logic                     resume,
  output logic                     jump_context_exchange,
  output logic [PC_WIDTH-1:0]      saved_pc,
  output logic                     in_kernel,
  output logic [7:0]               preempt_count
);
  import galetron_ctx_pkg::*;

  ctx_state_e               state_q, state_d;
  logic                     enable_q;
  logic [QUANTUM_WIDTH-1:0] quantum_q;
  logic [PC_WIDTH-1:0]      saved_pc_q, saved_pc_d;
  logic                     in_kernel_q, in_kernel_d;
  logic                     ld, dec, rem_zero, fire;
  logic [QUANTUM_WIDTH-1:0] ld_val;
  logic                     eff_en;
  logic [QUANTUM_WIDTH-1:0] eff_q;

  // A config write coinciding with resume wins over the stored settings.
  assign eff_en = cfg_write ? cfg_enable  : enable_q;
  assign eff_q  = cfg_write ? cfg_quantum : quantum_q;

  always_comb begin
    state_d     = state_q;
    saved_pc_d  = saved_pc_q;
    in_kernel_d = in_kernel_q;
    ld          = 1'b0;
    ld_val      = quantum_q;
    dec         = 1'b0;
    fire        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_q && quantum_q != '0) begin
          state_d = COUNTING;
          ld      = 1'b1;
        end
      end
      COUNTING: begin
        if (cfg_write) begin
          if (!cfg_enable || cfg_quantum == '0) state_d = IDLE;
          else begin
            ld     = 1'b1;
            ld_val = cfg_quantum;
          end
        end else if (rem_zero) begin
          // Halted or branching cycles defer the exchange so a taken jump is never lost.
          if (!HLT && !ctrl_transfer) begin
            fire        = 1'b1;
            state_d     = KERNEL;
            in_kernel_d = 1'b1;
            saved_pc_d  = programCounter + 1'b1;
          end
        end else begin
          dec = !HLT;
        end
      end
      KERNEL: begin
        if (resume) begin
          in_kernel_d = 1'b0;
          ld          = 1'b1;
          ld_val      = eff_q;
          state_d     = (eff_en && eff_q != '0) ? COUNTING : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetCPU) begin
      state_q     <= IDLE;
      enable_q    <= 1'b0;
      quantum_q   <= RESET_QUANTUM;
      saved_pc_q  <= '0;
      in_kernel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_pc_q  <= saved_pc_d;
      in_kernel_q <= in_kernel_d;
      if (cfg_write) begin
        enable_q  <= cfg_enable;
        quantum_q <= cfg_quantum;
      end
    end
  end

  quantum_down_counter #(.W(QUANTUM_WIDTH)) u_rem (
    .clk_i      (clock),
    .rst_i      (resetCPU),
    .load_i     (ld),
    .load_val_i (ld_val),
    .dec_i      (dec),
    .zero_o     (rem_zero)
  );

  assign jump_context_exchange = fire && !resetCPU;
  assign saved_pc              = saved_pc_q;
  assign in_kernel             = in_kernel_q;

`ifdef CTX_PREEMPT_STATS_EN
  logic [7:0] preempt_count_q;
  always_ff @(posedge clock) begin
    if (resetCPU)                          preempt_count_q <= '0;
    else if (fire && preempt_count_q != 8'hFF) preempt_count_q <= preempt_count_q + 8'd1;
  end
  assign preempt_count = preempt_count_q;
`else
  assign preempt_count = '0;
`endif

endmodule

// File: doc/context_switch_timer.md
Name: context_switch_timer

Overview:
Preemption controller sitting directly upstream of the program counter. It counts retired instructions of the running process against a programmable quantum. On expiry it drives the PC's jump_context_exchange input for exactly one cycle, which vectors the PC to the OS handler, and latches the return address for the OS to read. It then holds off until the OS signals resume.

Parameters:
PC_WIDTH, 12, width of programCounter and saved_pc
QUANTUM_WIDTH, 16, width of quantum register and down-counter
RESET_QUANTUM, 16'd1000, quantum value loaded by reset

Ports:
clock  in  1  system clock, all state on posedge
resetCPU  in  1  synchronous, active-high reset
programCounter  in  PC_WIDTH  current PC, from the PC block
HLT  in  1  processor halted; no instruction retires this cycle
ctrl_transfer  in  1  taken jump or branch this cycle (jump | select)
cfg_write  in  1  OS write strobe for enable/quantum
cfg_enable  in  1  preemption enable value written on cfg_write
cfg_quantum  in  QUANTUM_WIDTH  quantum value written on cfg_write
resume  in  1  one-cycle pulse when OS returns to a process
jump_context_exchange  out  1  to the PC; one-cycle preemption request
saved_pc  out  PC_WIDTH  return address of the preempted process
in_kernel  out  1  high from exchange until resume
preempt_count  out  8  preemption statistic (see Optional Feature)

Behaviour:
- Reset (resetCPU=1 at posedge): state=IDLE, enable=0, quantum=RESET_QUANTUM, remaining=0, saved_pc=0, in_kernel=0, preempt_count=0. jump_context_exchange is 0 while resetCPU=1. Reset mid-count or in KERNEL aborts everything.
- cfg_write: at posedge, enable<=cfg_enable and quantum<=cfg_quantum. Accepted in every state.
- States:
  - IDLE: go to COUNTING with remaining<=quantum when enable=1 and quantum!=0. A cfg_write to an enabled, nonzero quantum takes effect from the next cycle.
  - COUNTING: a cfg_write with cfg_enable=0 or cfg_quantum=0 returns to IDLE. Any other cfg_write reloads remaining<=cfg_quantum. Otherwise, when HLT=0 and remaining!=0, remaining decrements. HLT=1 freezes remaining.
  - FIRE condition (evaluated in COUNTING, no cfg_write): remaining==0 and HLT=0 and ctrl_transfer=0.
    - jump_context_exchange=1 combinationally in that same cycle (Mealy; the PC samples it at the edge).
    - At the edge: saved_pc<=programCounter+1 (modulo 2^PC_WIDTH, so 4095 wraps to 0), in_kernel<=1, state<=KERNEL.
  - Deferral: if remaining==0 and HLT=1 or ctrl_transfer=1, the exchange is deferred cycle by cycle. A taken jump or branch is therefore never overwritten by the exchange.
  - KERNEL: jump_context_exchange=0 and counting stops. resume=1 gives in_kernel<=0 and remaining<=quantum. If cfg_write coincides, the new quantum is used. Next state is COUNTING if enable and quantum!=0, else IDLE. resume outside KERNEL is ignored.
- Timing: quantum N gives N non-halted cycles counted, then the exchange fires on the next eligible cycle. The instruction in the firing cycle completes.
- saved_pc is stable from the edge after FIRE until the next FIRE or reset.
- jump_context_exchange is never high on two consecutive cycles.

Optional Feature:
CTX_PREEMPT_STATS_EN
- Defined: preempt_count increments at every FIRE edge, saturates at 255, and is cleared only by reset.
- Undefined: preempt_count is tied to 0 and no counter register exists.

Decomposition:
- Package galetron_ctx_pkg holds:
  - state enum {IDLE, COUNTING, KERNEL}
  - PC_WIDTH
  - HANDLER_ADDR=12'd1083 (documentation/bench use)
  - RESET_QUANTUM
- One natural sub-module: quantum_down_counter. It provides load/enable/zero-flag over QUANTUM_WIDTH and is instantiated once.

Test Plan:
- Reset; cfg_write enable=1, quantum=5; HLT=0, ctrl_transfer=0, PC=300..; after 5 counted cycles the exchange fires in the next cycle with PC=305 -> jump_context_exchange=1 for 1 cycle, saved_pc=306, in_kernel=1.
- quantum=3; HLT=1 for 4 cycles mid-count -> firing delayed by exactly 4 cycles; remaining frozen throughout.
- remaining==0 while ctrl_transfer=1 for 2 cycles, then 0 at PC=420 -> no pulse during the 2 cycles; pulse at PC=420, saved_pc=421.
- Fire at PC=4095 -> saved_pc=0. In KERNEL, resume together with cfg_write quantum=2 -> exchange fires after 2 counted cycles.
- cfg_write enable=0 mid-count -> IDLE, no pulse ever. resetCPU=1 while in KERNEL -> in_kernel=0, saved_pc=0 next cycle.
- With CTX_PREEMPT_STATS_EN: 260 preemptions -> preempt_count=255. Without the macro -> preempt_count stays 0.
